// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and single-port memory signals that
// connect to mem_port_arbiter.
//   slave  : arbiter side (takes requests, drives completions and memory)
//   master : requester / memory side (drives requests, takes completions)
// Fetch : f_req, f_addr -> f_valid, f_rdata, f_err
// Data  : d_req, d_we, d_addr, d_wdata -> d_valid, d_rdata, d_err
// Memory: mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata (one cycle later)
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_valid;
    logic [DATA_W-1:0] f_rdata;
    logic              f_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr,
        output f_valid, f_rdata, f_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_valid, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output f_req, f_addr,
        input  f_valid, f_rdata, f_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_valid, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between the fetch unit (read-only) and
// the memory stage (read/write). One outstanding request per port, round-robin
// on contention, one memory access cycle per grant, out-of-range addresses
// complete with an error flag and never touch the memory.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_port_arbiter_if.slave (fetch port, data port, memory)
module mem_port_arbiter #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned MEM_LIMIT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_port_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t              state_q;
    logic                rr_q;          // 0: data wins a tie, 1: fetch wins
    logic                owner_d_q;     // 1: data port owns the access
    logic                we_q;
    logic                err_q;

    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic                f_valid_q;
    logic [DATA_W-1:0]   f_rdata_q;
    logic                f_err_q;
    logic                d_valid_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                d_err_q;

    logic                f_elig_c;
    logic                d_elig_c;
    logic                grant_d_c;
    logic                grant_f_c;
    logic [ADDR_W-1:0]   sel_addr_c;
    logic [DATA_W-1:0]   sel_wdata_c;
    logic                sel_we_c;
    logic                sel_err_c;
    logic [DATA_W-1:0]   rdata_next_c;

    // Request selection; a port is ignored while its own completion is
    // showing so a still-held request is not accepted twice.
    always_comb begin
        f_elig_c     = bus.f_req && !f_valid_q;
        d_elig_c     = bus.d_req && !d_valid_q;
        grant_d_c    = d_elig_c && (!f_elig_c || !rr_q);
        grant_f_c    = f_elig_c && !grant_d_c;
        sel_addr_c   = grant_d_c ? bus.d_addr : bus.f_addr;
        sel_wdata_c  = grant_d_c ? bus.d_wdata : '0;
        sel_we_c     = grant_d_c && bus.d_we;
        sel_err_c    = (sel_addr_c >= ADDR_W'(MEM_LIMIT));
        rdata_next_c = (we_q || err_q) ? '0 : bus.mem_rdata;
    end

    // Sequencer: IDLE grants and launches the access, ACCESS is the memory
    // cycle, WAIT returns the result to the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            owner_d_q   <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f_valid_q   <= 1'b0;
            f_rdata_q   <= '0;
            f_err_q     <= 1'b0;
            d_valid_q   <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            f_valid_q <= 1'b0;
            f_err_q   <= 1'b0;
            d_valid_q <= 1'b0;
            d_err_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (grant_d_c || grant_f_c) begin
                        state_q   <= ACCESS;
                        owner_d_q <= grant_d_c;
                        we_q      <= sel_we_c;
                        err_q     <= sel_err_c;
                        rr_q      <= grant_d_c;
                        // Memory bus stays all-zero for an illegal address.
                        mem_en_q    <= !sel_err_c;
                        mem_we_q    <= !sel_err_c && sel_we_c;
                        mem_addr_q  <= sel_err_c ? '0 : sel_addr_c;
                        mem_wdata_q <= sel_err_c ? '0 : sel_wdata_c;
                    end
                end

                ACCESS: begin
                    state_q     <= WAIT;
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                end

                WAIT: begin
                    state_q <= IDLE;
                    if (owner_d_q) begin
                        d_valid_q <= 1'b1;
                        d_err_q   <= err_q;
                        d_rdata_q <= rdata_next_c;
                    end else begin
                        f_valid_q <= 1'b1;
                        f_err_q   <= err_q;
                        f_rdata_q <= rdata_next_c;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.f_valid   = f_valid_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.f_err     = f_err_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter sharing one single-port data memory between the fetch unit (read-only) and the memory stage (read/write) of the Y86-64 core. Accepts one outstanding request per port, selects a winner round-robin on contention, drives the memory for a single access cycle and returns read data, completion and an out-of-range error flag. Replaces direct memory-stage ownership of the array when fetch and data share storage.

## Interface
- DATA_W, 64, data width of memory word and request data
- ADDR_W, 64, byte address width (valE / PC width)
- MEM_LIMIT, 1024, first illegal address; any address >= MEM_LIMIT is an error
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- f_req  in  1  fetch read request, held until f_valid
- f_addr  in  ADDR_W  fetch address, stable while f_req
- f_valid  out  1  fetch completion pulse (1 cycle)
- f_rdata  out  DATA_W  fetch read data, valid with f_valid
- f_err  out  1  fetch address error, valid with f_valid
- d_req  in  1  data-stage request, held until d_valid
- d_we  in  1  1 = write (rmmovq/pushq/call), 0 = read (mrmovq/popq/ret)
- d_addr  in  ADDR_W  data address (valE or valA)
- d_wdata  in  DATA_W  write data (valA or valP)
- d_valid  out  1  data completion pulse (1 cycle)
- d_rdata  out  DATA_W  read data (valM), valid with d_valid
- d_err  out  1  data address error (dmem_error), valid with d_valid
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en read cycle

## Operation
- States: IDLE, ACCESS, WAIT. All state, latched request and outputs are registers.
- IDLE: if any eligible req, latch owner, we, addr, wdata; go ACCESS. Else stay.
- Eligibility: a port is masked in the cycle its own valid is high (prevents re-accepting a held req).
- Arbitration: single eligible req always wins. Both eligible: rr=0 -> data wins, rr=1 -> fetch wins. After grant, rr points to the other port. rr resets to 0.
- ACCESS (1 cycle): addr < MEM_LIMIT -> mem_en=1, mem_we=latched we (0 for fetch), mem_addr/mem_wdata from latch. addr >= MEM_LIMIT -> mem_en=0, mem_we=0, error latched. Go WAIT.
- WAIT (1 cycle): capture mem_rdata (read, no error) or 0 (write or error) into owner's rdata; owner's valid=1 and err=latched error in next cycle; go IDLE.
- Non-owner valid/err stay 0; non-owner rdata holds previous value.
- mem_addr/mem_wdata/mem_we are 0 whenever mem_en=0.
- A request arriving while not IDLE waits; req must stay high and inputs stable until its valid.

## Timing
- Reset (async assert): state=IDLE, rr=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, f_valid=d_valid=0, f_err=d_err=0, f_rdata=d_rdata=0. In-flight access is dropped, no valid issued, no write completes after reset assertion.
- Latency: req sampled at edge E0 in IDLE -> mem_en high cycle after E0 -> valid high cycle after E0+2 (3 cycles from sampling edge to valid cycle).
- Back-to-back: IDLE accepts at the edge ending the valid cycle; competing port's req, held throughout, is accepted at that same edge. Sustained contention alternates d, f, d, f with one grant every 3 cycles.
- Simultaneous first requests after reset: data served first.
- Write commits at the edge ending ACCESS.

## Test plan
- Reset mid-access: d_req write to 100 of 49, rst_n low during ACCESS -> mem_en drops immediately, no d_valid, mem[100] unchanged, all outputs 0.
- Data write then read: d_we=1 d_addr=200 d_wdata=109, then d_we=0 d_addr=200 -> first d_valid with d_rdata=0 d_err=0; second d_valid 3 cycles after its sampling edge with d_rdata=109.
- Signed data: write -49 at 250, read 250 -> d_rdata=0xFFFFFFFFFFFFFFCF.
- Contention: f_req addr 0 and d_req read addr 100 same edge after reset -> data granted first, fetch mem_en 3 cycles later; f_valid 3 cycles after d_valid; next tie grants data again only after a fetch grant.
- Out of range: d_addr=1024 write -> mem_en never asserted, d_valid with d_err=1, d_rdata=0; f_addr=2000 -> f_err=1.
- Held-req masking: fetch holds f_req one cycle past f_valid -> exactly one fetch access issued, no duplicate mem_en.
